// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor scheduler: FSM state
// encoding, direction constants, bus widths and the descriptor record.
package dma_pkg;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

  localparam logic MODE_CPU_TO_MEM = 1'b1;
  localparam logic MODE_MEM_TO_CPU = 1'b0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              mode;
  } desc_t;

endpackage

// File: rtl/dma_rr_arb2.sv
// Combinational two-way round-robin grant: a lone requester wins, and on a
// tie the channel that did not go last wins.
module dma_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_ch,
  output logic       grant,
  output logic       grant_any
);

  always_comb begin
    grant_any = |valid;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_ch;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/dma_channel_sched.sv
// Two-channel descriptor scheduler for the DMA engine.
// Optional idle-beat watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_channel_sched
  import dma_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_enable,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req0_mode,
  input  logic              req1_valid,
  output logic              req1_enable,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  input  logic              req1_mode,
  output logic              dma_addr_valid,
  input  logic              dma_addr_enable,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  output logic              dma_mode,
  input  logic              beat_fire,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic              busy,
  output logic              active_ch
);

  logic [1:0]       state;
  desc_t            desc;
  desc_t            sel;
  logic             act;
  logic             last_ch;
  logic [LEN_W-1:0] cnt;
  logic             grant;
  logic             grant_any;
  logic             take;
  logic             abort;

  dma_rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .last_ch  (last_ch),
    .grant    (grant),
    .grant_any(grant_any)
  );

  // Enables are held low while resetn is asserted so reset values hold
  // even if a requester is already presenting.
  assign take        = resetn && (state == ST_IDLE) && grant_any;
  assign req0_enable = take && !grant;
  assign req1_enable = take && grant;

  always_comb begin
    sel.addr = grant ? req1_addr : req0_addr;
    sel.len  = grant ? req1_len  : req0_len;
    sel.mode = grant ? req1_mode : req0_mode;
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  logic [LEN_W-1:0] idle_cnt;
  assign err = (state == ST_DONE) && abort;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      desc    <= '0;
      act     <= 1'b0;
      last_ch <= 1'b1;
      cnt     <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      idle_cnt <= '0;
      abort    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            desc  <= sel;
            act   <= grant;
            state <= (sel.len == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dma_addr_enable) begin
            cnt   <= '0;
            state <= ST_XFER;
`ifdef DMA_SCHED_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        ST_XFER: begin
          if (beat_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == desc.len - 1'b1) state <= ST_DONE;
          end
`ifdef DMA_SCHED_TIMEOUT_EN
          if (beat_fire) begin
            idle_cnt <= '0;
          end else if (idle_cnt == LEN_W'(TIMEOUT - 1)) begin
            state <= ST_DONE;
            abort <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        default: begin
          last_ch <= act;
          state   <= ST_IDLE;
`ifdef DMA_SCHED_TIMEOUT_EN
          abort <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign dma_addr_valid = (state == ST_ISSUE);
  assign dma_addr       = desc.addr;
  assign dma_len        = desc.len;
  assign dma_mode       = desc.mode;
  assign busy           = (state != ST_IDLE);
  assign active_ch      = act;
  assign done0          = (state == ST_DONE) && !act && !abort;
  assign done1          = (state == ST_DONE) && act && !abort;

endmodule

// File: tb/tb_dma_channel_sched.sv
// Self-checking bench for dma_channel_sched (default build, watchdog off);
// a negedge monitor logs handshakes and pulses, scenarios check against a model.
module tb_dma_channel_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_enable, req1_enable;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_len = '0, req1_len = '0;
  logic        req0_mode = 1'b0, req1_mode = 1'b0;
  logic        dma_addr_valid;
  logic        dma_addr_enable = 1'b0;
  logic [31:0] dma_addr, dma_len;
  logic        dma_mode;
  logic        beat_fire = 1'b0;
  logic        done0, done1, err, busy, active_ch;

  int checks = 0;
  int failures = 0;

  dma_channel_sched #(.TIMEOUT(1024)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_enable(req0_enable), .req0_addr(req0_addr),
    .req0_len(req0_len), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_enable(req1_enable), .req1_addr(req1_addr),
    .req1_len(req1_len), .req1_mode(req1_mode),
    .dma_addr_valid(dma_addr_valid), .dma_addr_enable(dma_addr_enable),
    .dma_addr(dma_addr), .dma_len(dma_len), .dma_mode(dma_mode),
    .beat_fire(beat_fire), .done0(done0), .done1(done1), .err(err),
    .busy(busy), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  // Monitor state
  int          cyc = 0;
  int          acc_q[$];
  logic [64:0] iss_q[$];
  int          acc_cyc = 0, rise_cyc = 0, done_cyc = 0;
  int          rises = 0, n_done0 = 0, n_done1 = 0, n_err = 0;
  int          dual_en = 0, mode_glitch = 0;
  logic        prev_valid = 1'b0, prev_busy = 1'b0, prev_mode = 1'b0;
  int          last_beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req0_valid && req0_enable) begin acc_q.push_back(0); acc_cyc <= cyc; end
    if (req1_valid && req1_enable) begin acc_q.push_back(1); acc_cyc <= cyc; end
    if (req0_enable && req1_enable) dual_en <= dual_en + 1;
    if (dma_addr_valid && dma_addr_enable) iss_q.push_back({dma_addr, dma_len, dma_mode});
    if (dma_addr_valid && !prev_valid) begin rises <= rises + 1; rise_cyc <= cyc; end
    if (done0) begin n_done0 <= n_done0 + 1; done_cyc <= cyc; end
    if (done1) begin n_done1 <= n_done1 + 1; done_cyc <= cyc; end
    if (err) n_err <= n_err + 1;
    if (prev_busy && busy && dma_mode != prev_mode) mode_glitch <= mode_glitch + 1;
    prev_valid <= dma_addr_valid;
    prev_busy  <= busy;
    prev_mode  <= dma_mode;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    dma_addr_enable = 1'b0; beat_fire = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic present(input int ch, input logic [31:0] a, input logic [31:0] l, input logic m);
    if (ch == 0) begin req0_addr = a; req0_len = l; req0_mode = m; req0_valid = 1'b1; end
    else begin req1_addr = a; req1_len = l; req1_mode = m; req1_valid = 1'b1; end
  endtask

  // Bounded wait for the next accepted descriptor; an expired bound is a failure.
  task automatic wait_accept(output int ch);
    int n = acc_q.size();
    int t = 0;
    while (acc_q.size() == n && t < 20) begin tick(); t++; end
    checks++;
    if (acc_q.size() == n) begin
      failures++;
      $display("FAIL accept_timeout got=none exp=accept within 20 cycles");
      ch = -1;
    end else begin
      ch = acc_q[$];
    end
  endtask

  // Engine side of one transfer: random issue hold-off, then len beats with random gaps.
  task automatic serve(input logic [31:0] len);
    if (len == 0) begin tick(); return; end
    repeat ($urandom_range(0, 3)) tick();
    dma_addr_enable = 1'b1; tick(); dma_addr_enable = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      repeat ($urandom_range(0, 2)) tick();
      beat_fire = 1'b1; last_beat_cyc = cyc; tick(); beat_fire = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, dma_addr_valid, dma_mode, done0, done1, err, active_ch, req0_enable, req1_enable} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, dma_addr_valid, dma_mode, done0, done1, err,
               active_ch, req0_enable, req1_enable}, 9'b0);
    end
    checks++;
    if (dma_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", dma_addr, 32'h0); end
    checks++;
    if (dma_len !== 32'h0) begin failures++; $display("FAIL reset_len got=%h exp=%h", dma_len, 32'h0); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int ch, d0, d1, na;
    do_reset();
    d0 = n_done0; d1 = n_done1; na = acc_q.size();
    present(0, 32'h1000, 32'd12, 1'b1);
    wait_accept(ch);
    // requester still valid while busy: must not be re-accepted
    tick();
    checks++;
    if (req0_enable !== 1'b0 || acc_q.size() != na + 1) begin
      failures++;
      $display("FAIL single_enable_once got=en%b acc%0d exp=en0 acc%0d", req0_enable, acc_q.size() - na, 1);
    end
    req0_valid = 1'b0;
    checks++;
    if ({dma_addr_valid, dma_addr, dma_len, dma_mode} !== {1'b1, 32'h1000, 32'd12, 1'b1}) begin
      failures++;
      $display("FAIL single_issue got=v%b a%h l%0d m%b exp=v1 a00001000 l12 m1",
               dma_addr_valid, dma_addr, dma_len, dma_mode);
    end
    checks++;
    if (rise_cyc != acc_cyc + 1) begin
      failures++;
      $display("FAIL single_issue_latency got=%0d exp=%0d", rise_cyc - acc_cyc, 1);
    end
    serve(32'd12);
    checks++;
    if (n_done0 - d0 != 1 || n_done1 - d1 != 0) begin
      failures++;
      $display("FAIL single_done got=d0:%0d d1:%0d exp=d0:1 d1:0", n_done0 - d0, n_done1 - d1);
    end
    checks++;
    if (done_cyc != last_beat_cyc + 1) begin
      failures++;
      $display("FAIL single_done_latency got=%0d exp=%0d", done_cyc - last_beat_cyc, 1);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=%b", busy, 1'b0); end
  endtask

  task automatic test_tie();
    int ch, d0, d1;
    logic [31:0] a0, a1;
    do_reset();
    d0 = n_done0; d1 = n_done1;
    a0 = $urandom; a1 = $urandom;
    present(0, a0, 32'd3, 1'b0);
    present(1, a1, 32'd5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_accept(ch);
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      checks++;
      if (ch != k % 2) begin
        failures++;
        $display("FAIL tie_grant_%0d got=%0d exp=%0d", k, ch, k % 2);
      end
      serve(k % 2 == 1 ? 32'd5 : 32'd3);
      checks++;
      if (iss_q.size() == 0 || iss_q[$] !== (k % 2 == 1 ? {a1, 32'd5, 1'b1} : {a0, 32'd3, 1'b0})) begin
        failures++;
        $display("FAIL tie_desc_%0d got=%h exp=%h", k, iss_q.size() ? iss_q[$] : 65'h0,
                 (k % 2 == 1 ? {a1, 32'd5, 1'b1} : {a0, 32'd3, 1'b0}));
      end
    end
    checks++;
    if (n_done0 - d0 != 2 || n_done1 - d1 != 2) begin
      failures++;
      $display("FAIL tie_done got=d0:%0d d1:%0d exp=d0:2 d1:2", n_done0 - d0, n_done1 - d1);
    end
  endtask

  task automatic test_zero_len();
    int ch, r, ni, d1;
    r = rises; ni = iss_q.size(); d1 = n_done1;
    present(1, $urandom, 32'd0, 1'($urandom));
    wait_accept(ch);
    req1_valid = 1'b0;
    checks++;
    if ({done1, done0, busy, dma_addr_valid} !== 4'b1010) begin
      failures++;
      $display("FAIL zero_done_now got=%b exp=%b", {done1, done0, busy, dma_addr_valid}, 4'b1010);
    end
    tick();
    checks++;
    if ({done1, busy} !== 2'b00) begin
      failures++;
      $display("FAIL zero_back_idle got=%b exp=%b", {done1, busy}, 2'b00);
    end
    checks++;
    if (rises != r || iss_q.size() != ni || n_done1 - d1 != 1 || done_cyc != acc_cyc + 1) begin
      failures++;
      $display("FAIL zero_no_issue got=rise%0d iss%0d done%0d lat%0d exp=rise0 iss0 done1 lat1",
               rises - r, iss_q.size() - ni, n_done1 - d1, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_ignored_beats();
    int ch, d0;
    do_reset();
    d0 = n_done0;
    beat_fire = 1'b1;
    tick(); tick();
    present(0, $urandom, 32'd5, 1'($urandom));
    wait_accept(ch);
    req0_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (dma_addr_valid !== 1'b1) begin
      failures++;
      $display("FAIL ign_still_issue got=%b exp=%b", dma_addr_valid, 1'b1);
    end
    beat_fire = 1'b0;
    dma_addr_enable = 1'b1; tick(); dma_addr_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin beat_fire = 1'b1; tick(); beat_fire = 1'b0; tick(); end
    tick();
    checks++;
    if (n_done0 != d0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ign_early_done got=done%0d busy%b exp=done0 busy1", n_done0 - d0, busy);
    end
    beat_fire = 1'b1; tick(); beat_fire = 1'b0;
    checks++;
    if (done0 !== 1'b1) begin failures++; $display("FAIL ign_final_done got=%b exp=%b", done0, 1'b1); end
    tick();
  endtask

  task automatic test_reset_mid();
    int ch, d0, e0;
    do_reset();
    present(0, $urandom, 32'd12, 1'b1);
    wait_accept(ch);
    req0_valid = 1'b0;
    dma_addr_enable = 1'b1; tick(); dma_addr_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin beat_fire = 1'b1; tick(); beat_fire = 1'b0; end
    d0 = n_done0; e0 = n_err;
    resetn = 1'b0; tick();
    checks++;
    if ({busy, dma_addr_valid, dma_mode, done0, done1, err, active_ch, req0_enable, req1_enable,
         dma_addr, dma_len} !== 73'b0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b%b%b%b%b%b%b a%h l%h exp=all zero", busy, dma_addr_valid,
               dma_mode, done0, done1, err, active_ch, dma_addr, dma_len);
    end
    resetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (n_done0 != d0 || n_err != e0) begin
      failures++;
      $display("FAIL midreset_no_pulse got=done%0d err%0d exp=done0 err0", n_done0 - d0, n_err - e0);
    end
    // tie straight after reset: channel 0 first
    present(0, $urandom, 32'd3, 1'b0);
    present(1, $urandom, 32'd7, 1'b1);
    wait_accept(ch);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (ch != 0) begin failures++; $display("FAIL midreset_tie got=%0d exp=%0d", ch, 0); end
    d0 = n_done0;
    serve(32'd3);
    checks++;
    if (n_done0 - d0 != 1 || done_cyc != last_beat_cyc + 1) begin
      failures++;
      $display("FAIL midreset_recount got=done%0d lat%0d exp=done1 lat1", n_done0 - d0, done_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_random();
    int ch, which, exp_ch, d0, d1, ni;
    int model_last;
    logic [31:0] a[2], l[2];
    logic        m[2];
    do_reset();
    model_last = 1;
    for (int r = 0; r < 16; r++) begin
      which = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++) begin
        a[c] = $urandom; l[c] = $urandom_range(0, 6); m[c] = 1'($urandom);
      end
      if (which == 3) exp_ch = 1 - model_last;
      else exp_ch = (which == 1) ? 0 : 1;
      d0 = n_done0; d1 = n_done1; ni = iss_q.size();
      if (which[0]) present(0, a[0], l[0], m[0]);
      if (which[1]) present(1, a[1], l[1], m[1]);
      wait_accept(ch);
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (ch != exp_ch) begin
        failures++;
        $display("FAIL rand_grant_%0d got=%0d exp=%0d", r, ch, exp_ch);
      end
      serve(l[exp_ch]);
      checks++;
      if (n_done0 - d0 != (exp_ch == 0 ? 1 : 0) || n_done1 - d1 != (exp_ch == 1 ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_done_%0d got=d0:%0d d1:%0d exp_ch=%0d", r, n_done0 - d0, n_done1 - d1, exp_ch);
      end
      checks++;
      if (l[exp_ch] == 0 ? (iss_q.size() != ni)
                         : (iss_q.size() != ni + 1 || iss_q[$] !== {a[exp_ch], l[exp_ch], m[exp_ch]})) begin
        failures++;
        $display("FAIL rand_issue_%0d got=n%0d %h exp=%h", r, iss_q.size() - ni,
                 iss_q.size() ? iss_q[$] : 65'h0, {a[exp_ch], l[exp_ch], m[exp_ch]});
      end
      model_last = exp_ch;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_zero_len();
    test_ignored_beats();
    test_reset_mid();
    test_random();
    checks++;
    if (dual_en != 0 || mode_glitch != 0 || n_err != 0) begin
      failures++;
      $display("FAIL global_invariants got=dual%0d glitch%0d err%0d exp=0 0 0", dual_en, mode_glitch, n_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=still running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dma_channel_sched.md
# dma_channel_sched

Two-channel descriptor scheduler in front of the single address-capable DMA engine. It accepts transfer descriptors from two requesters. Each descriptor holds a 32-bit address, a 32-bit byte length and a direction mode. The block grants the engine round-robin, issues the descriptor on the engine's address/length handshake, and drives the engine's mode input. It counts completed byte beats and signals per-channel completion.

## Interface
Parameters:
- TIMEOUT, 1024: idle-beat watchdog limit in cycles; used only with DMA_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  reset; synchronous, active-low.
- req0_valid / req1_valid  in  1  requester N presents a descriptor.
- req0_enable / req1_enable  out  1  scheduler accepts requester N's descriptor this cycle.
- req0_addr / req1_addr  in  32  start address.
- req0_len / req1_len  in  32  length in bytes.
- req0_mode / req1_mode  in  1  direction: 1 = cpu_to_mem, 0 = mem_to_cpu.
- dma_addr_valid  out  1  descriptor valid toward engine address port.
- dma_addr_enable  in  1  engine accepts address/length.
- dma_addr  out  32  issued address.
- dma_len  out  32  issued length.
- dma_mode  out  1  engine direction.
- beat_fire  in  1  one 8-bit byte completed on the CPU side (valid&enable of the active direction).
- done0 / done1  out  1  one-cycle completion pulse per channel.
- err  out  1  one-cycle abort pulse; tied 0 without DMA_SCHED_TIMEOUT_EN.
- busy  out  1  state != IDLE.
- active_ch  out  1  channel currently owning the engine.

## Operation
- The FSM has four states: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - Grant is combinational. A single valid requester wins. If both are valid, the channel not equal to last_ch wins.
  - reqN_enable = (state==IDLE) & grant==N & reqN_valid. The other enable stays 0.
  - When reqN_valid & reqN_enable is sampled, latch addr, len and mode and set active_ch=N.
  - Go to ISSUE if len!=0. If len==0, go to DONE without issuing.
- ISSUE:
  - Hold dma_addr_valid=1 with stable dma_addr and dma_len.
  - When dma_addr_valid & dma_addr_enable is sampled, clear the byte counter and go to XFER.
- XFER:
  - On each beat_fire, increment the 32-bit counter.
  - On beat_fire with counter==len-1, go to DONE. The comparison is 32-bit unsigned with no wrap; len==0 never reaches this state.
- DONE:
  - Pulse done[active_ch] for exactly one cycle.
  - Set last_ch=active_ch and return to IDLE.
- dma_mode is updated only at descriptor accept. It holds its value through IDLE after completion and never changes mid-transfer.
- beat_fire is ignored in IDLE, ISSUE and DONE.
- Requester inputs are ignored outside IDLE. The descriptor register is not overwritten while busy.

## Timing
- Reset values: dma_addr_valid=0, dma_addr=0, dma_len=0, dma_mode=0, req*_enable=0, done*=0, err=0, busy=0, active_ch=0, counter=0, last_ch=1 (so channel 0 wins the first tie), state=IDLE.
- Accept edge to dma_addr_valid high: 1 cycle.
- Engine accept edge to XFER: 1 cycle.
- Final beat edge to done pulse: the done pulse is high during the cycle after the final beat.
- After the done pulse, the earliest next accept is 1 cycle later (IDLE). Minimum gap between two descriptors is therefore 2 cycles.
- len==0: accept, then DONE, then IDLE. The done pulse comes 1 cycle after accept and dma_addr_valid never asserts.
- Reset mid-operation returns everything to reset values the next edge. No done or err pulse is emitted for the abandoned descriptor.

## Configuration
- DMA_SCHED_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to XFER and on every beat_fire, and increments each XFER cycle.
  - When it reaches TIMEOUT, go to DONE with err=1 for one cycle instead of done[active_ch]. last_ch is still updated.
- DMA_SCHED_TIMEOUT_EN undefined:
  - There is no watchdog logic and err is constant 0.
  - XFER waits indefinitely.

## Structure
- Shared package dma_pkg holds:
  - the FSM state encoding (IDLE/ISSUE/XFER/DONE);
  - the MODE_CPU_TO_MEM=1 and MODE_MEM_TO_CPU=0 constants;
  - ADDR_W=32 and LEN_W=32;
  - a descriptor typedef {addr, len, mode}.
- One sub-module, dma_rr_arb2: a combinational 2-way round-robin grant taking valid[1:0] and last_ch, returning grant and grant_any. It is reusable by later multi-requester blocks.

## Test plan
- Channel 0 only, addr=0x1000, len=12, mode=1:
  - req0_enable is high for one cycle.
  - dma_addr_valid is high until enable, with dma_addr=0x1000, dma_len=12, dma_mode=1.
  - After 12 beat_fire pulses (random spacing), done0 pulses once and done1 stays 0.
- Both valid at reset exit (ch0 len=3, ch1 len=5): ch0 is granted first, then ch1. With both held valid, grants alternate 0,1,0,1 across four descriptors.
- len=0 on ch1: done1 pulses 1 cycle after accept, dma_addr_valid never rises and no beats are counted.
- beat_fire asserted in IDLE and ISSUE, with dma_addr_enable held low for 5 cycles: the counter stays 0 and the transfer still requires all len beats after issue.
- resetn low for 1 cycle after 4 of 12 beats: all outputs return to reset values, no done0 pulse, and the next descriptor starts its count from 0.
- With DMA_SCHED_TIMEOUT_EN and TIMEOUT=8, issue len=4 and send 2 beats then none: err pulses after 8 idle cycles, then the block is in IDLE with last_ch=0.
